// File: rtl/hazard_pkg.sv
// Shared encodings for the stall/flush controller.
// FSM states track a multi-cycle mul/div occupying EX.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_BUSY = 2'd1,
    S_MD_DONE = 2'd2
  } md_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_reg_match.sv
// Flags when an ID operand that is actually read names a
// non-zero destination register.
module hazard_reg_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 32
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             uses_rs_i,
  input  logic             uses_rt_i,
  input  logic [REG_W-1:0] dst_i,
  output logic             hit_o
);

  logic dst_nz;
  logic rs_hit;
  logic rt_hit;

  assign dst_nz = (dst_i != REG_W'(REG_ZERO));
  assign rs_hit = uses_rs_i && (rs_i == dst_i);
  assign rt_hit = uses_rt_i && (rt_i == dst_i);
  assign hit_o  = dst_nz && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for hazards forwarding cannot resolve:
// load-use, ID-stage branch operands and multi-cycle mul/div.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 32,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] IFID_RegisterRs,
  input  logic [REG_W-1:0] IFID_RegisterRt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             Branch_Taken,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [REG_W-1:0] IDEX_RegDst,
  input  logic             IDEX_MulDiv,
  input  logic             EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_RegDst,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             Busy,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int MDW =
    (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam int MD_INIT =
    (MULDIV_LAT >= 2) ? MULDIV_LAT - 2 : 0;
  localparam bit MD_EN = (MULDIV_LAT >= 2);

  logic hit_ex;
  logic hit_ex_ld;
  logic hit_mem;

  hazard_reg_match #(.REG_W(REG_W)) u_match_ld (
    .rs_i      (IFID_RegisterRs),
    .rt_i      (IFID_RegisterRt),
    .uses_rs_i (ID_UsesRs),
    .uses_rt_i (ID_UsesRt),
    .dst_i     (IDEX_RegDst),
    .hit_o     (hit_ex_ld)
  );

  hazard_reg_match #(.REG_W(REG_W)) u_match_ex (
    .rs_i      (IFID_RegisterRs),
    .rt_i      (IFID_RegisterRt),
    .uses_rs_i (ID_UsesRs),
    .uses_rt_i (ID_UsesRt),
    .dst_i     (IDEX_RegDst),
    .hit_o     (hit_ex)
  );

  hazard_reg_match #(.REG_W(REG_W)) u_match_mem (
    .rs_i      (IFID_RegisterRs),
    .rt_i      (IFID_RegisterRt),
    .uses_rs_i (ID_UsesRs),
    .uses_rt_i (ID_UsesRt),
    .dst_i     (EXMEM_RegDst),
    .hit_o     (hit_mem)
  );

  logic load_use;
  logic br_stall;
  logic id_stall;
  logic md_stall;

  assign load_use = IDEX_MemRead && hit_ex_ld;
  // A load feeding a branch matches in EX, then in MEM: two stalls.
  assign br_stall = ID_Branch &&
                    ((IDEX_RegWrite && hit_ex) ||
                     (EXMEM_MemRead && hit_mem));
  assign id_stall = load_use || br_stall;

  md_state_e       state_q, state_d;
  logic [MDW-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_stall = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (IDEX_MulDiv && MD_EN) begin
          md_stall = 1'b1;
          md_cnt_d = MDW'(MD_INIT);
          state_d  = (MULDIV_LAT == 2) ? S_MD_DONE : S_MD_BUSY;
        end
      end
      S_MD_BUSY: begin
        md_stall = 1'b1;
        md_cnt_d = md_cnt_q - MDW'(1);
        if (md_cnt_q == MDW'(1))
          state_d = S_MD_DONE;
      end
      S_MD_DONE: state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((id_stall || md_stall) && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_RUN;
      md_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    Busy         = 1'b0;
    if (!Reset) begin
      Busy = (state_q != S_RUN);
      // Mul/div freezes ID/EX outright, so it beats a bubble.
      if (md_stall) begin
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
      end else if (id_stall) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end else begin
        IFID_Flush = Branch_Taken;
      end
    end
  end

  assign Stall_Count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed checks for hazard_stall_unit (LAT=4, 4-bit
// stall counter so saturation is reachable quickly).
module tb_hazard_stall_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IFID_RegisterRs, IFID_RegisterRt;
  logic        ID_UsesRs, ID_UsesRt, ID_Branch, Branch_Taken;
  logic        IDEX_MemRead, IDEX_RegWrite, IDEX_MulDiv;
  logic [31:0] IDEX_RegDst, EXMEM_RegDst;
  logic        EXMEM_MemRead;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Write;
  logic        IDEX_Bubble, EXMEM_Bubble, Busy;
  logic [3:0]  Stall_Count;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  hazard_stall_unit #(
    .REG_W(32), .MULDIV_LAT(4), .CNT_W(4)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .IFID_RegisterRs(IFID_RegisterRs),
    .IFID_RegisterRt(IFID_RegisterRt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .Branch_Taken(Branch_Taken),
    .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_RegDst(IDEX_RegDst), .IDEX_MulDiv(IDEX_MulDiv),
    .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_RegDst(EXMEM_RegDst),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Write(IDEX_Write),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
    .Busy(Busy), .Stall_Count(Stall_Count)
  );

  task automatic clr();
    IFID_RegisterRs = 0; IFID_RegisterRt = 0;
    ID_UsesRs = 0; ID_UsesRt = 0;
    ID_Branch = 0; Branch_Taken = 0;
    IDEX_MemRead = 0; IDEX_RegWrite = 0;
    IDEX_RegDst = 0; IDEX_MulDiv = 0;
    EXMEM_MemRead = 0; EXMEM_RegDst = 0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled
  // mid-cycle, away from the rising edge.
  task automatic tick();
    @(posedge Clk); #2;
  endtask

  // ctl = {PC_Write,IFID_Write,IFID_Flush,IDEX_Write,
  //        IDEX_Bubble,EXMEM_Bubble,Busy}
  task automatic test_reset();
    logic [6:0] ctl;
    clr();
    Reset = 1;
    IDEX_MulDiv = 1; IDEX_MemRead = 1; IDEX_RegDst = 5;
    IFID_RegisterRs = 5; ID_UsesRs = 1; Branch_Taken = 1;
    tick(); tick();
    ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
           IDEX_Bubble, EXMEM_Bubble, Busy};
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 1101000", ctl);
    end
    checks++;
    if (Stall_Count !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", Stall_Count);
    end
    clr();
    Reset = 0;
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] ctl;
    IDEX_MemRead = 1; IDEX_RegDst = 5;
    IFID_RegisterRs = 5; ID_UsesRs = 1;
    #1;
    ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
           IDEX_Bubble, EXMEM_Bubble, Busy};
    checks++;
    if (ctl !== 7'b0001100) begin
      errors++;
      $display("FAIL load_use_ctl got %b want 0001100", ctl);
    end
    tick();
    clr();
    #1;
    checks++;
    if (PC_Write !== 1'b1 || Stall_Count !== 4'd1) begin
      errors++;
      $display("FAIL load_use_after got pc=%b cnt=%0d want pc=1 cnt=1",
               PC_Write, Stall_Count);
    end
    // rt side, but ID does not read rt: no stall
    IDEX_MemRead = 1; IDEX_RegDst = 7;
    IFID_RegisterRt = 7; ID_UsesRt = 0;
    #1;
    checks++;
    if (PC_Write !== 1'b1) begin
      errors++;
      $display("FAIL load_use_unused got %b want 1", PC_Write);
    end
    tick();
    clr();
  endtask

  task automatic test_dst_zero();
    IDEX_MemRead = 1; IDEX_RegDst = 0;
    IFID_RegisterRs = 0; ID_UsesRs = 1;
    #1;
    checks++;
    if (PC_Write !== 1'b1 || IDEX_Bubble !== 1'b0) begin
      errors++;
      $display("FAIL dst_zero got pc=%b bub=%b want pc=1 bub=0",
               PC_Write, IDEX_Bubble);
    end
    tick();
    clr();
    #1;
    checks++;
    if (Stall_Count !== 4'd1) begin
      errors++;
      $display("FAIL dst_zero_cnt got %0d want 1", Stall_Count);
    end
  endtask

  task automatic test_branch();
    ID_Branch = 1; Branch_Taken = 1;
    IDEX_RegWrite = 1; IDEX_RegDst = 8;
    IFID_RegisterRt = 8; ID_UsesRt = 1;
    #1;
    checks++;
    if (PC_Write !== 1'b0 || IFID_Flush !== 1'b0 ||
        IDEX_Bubble !== 1'b1) begin
      errors++;
      $display("FAIL br_stall got pc=%b fl=%b bub=%b want 0 0 1",
               PC_Write, IFID_Flush, IDEX_Bubble);
    end
    tick();
    IDEX_RegDst = 9;
    #1;
    checks++;
    if (PC_Write !== 1'b1 || IFID_Flush !== 1'b1) begin
      errors++;
      $display("FAIL br_flush got pc=%b fl=%b want 1 1",
               PC_Write, IFID_Flush);
    end
    tick();
    // load two ahead feeding the branch: MEM-stage match
    IDEX_RegWrite = 0; IDEX_RegDst = 0;
    EXMEM_MemRead = 1; EXMEM_RegDst = 8;
    #1;
    checks++;
    if (PC_Write !== 1'b0 || IFID_Flush !== 1'b0) begin
      errors++;
      $display("FAIL br_mem got pc=%b fl=%b want 0 0",
               PC_Write, IFID_Flush);
    end
    tick();
    clr();
    #1;
    checks++;
    if (Stall_Count !== 4'd3) begin
      errors++;
      $display("FAIL br_cnt got %0d want 3", Stall_Count);
    end
  endtask

  task automatic test_muldiv();
    logic [2:0] exp_v [4];
    logic [2:0] got;
    // {IDEX_Write, EXMEM_Bubble, Busy} per cycle
    exp_v[0] = 3'b010; exp_v[1] = 3'b011;
    exp_v[2] = 3'b011; exp_v[3] = 3'b101;
    IDEX_MulDiv = 1; Branch_Taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      got = {IDEX_Write, EXMEM_Bubble, Busy};
      checks++;
      if (got !== exp_v[i]) begin
        errors++;
        $display("FAIL md_cyc%0d got %b want %b", i, got, exp_v[i]);
      end
      if (i < 3) begin
        checks++;
        if (IFID_Flush !== 1'b0 || PC_Write !== 1'b0) begin
          errors++;
          $display("FAIL md_flush%0d got fl=%b pc=%b want 0 0",
                   i, IFID_Flush, PC_Write);
        end
      end
      tick();
    end
    clr();
    #1;
    checks++;
    if (Busy !== 1'b0 || Stall_Count !== 4'd6) begin
      errors++;
      $display("FAIL md_end got busy=%b cnt=%0d want 0 6",
               Busy, Stall_Count);
    end
  endtask

  task automatic test_back_to_back();
    logic pat [8];
    for (int i = 0; i < 8; i++) pat[i] = (i % 4) != 3;
    IDEX_MulDiv = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (IDEX_Write !== !pat[i]) begin
        errors++;
        $display("FAIL b2b_cyc%0d got wr=%b want %b",
                 i, IDEX_Write, !pat[i]);
      end
      tick();
    end
    clr();
    #1;
    checks++;
    if (Stall_Count !== 4'd12) begin
      errors++;
      $display("FAIL b2b_cnt got %0d want 12", Stall_Count);
    end
  endtask

  task automatic test_md_priority_reset();
    logic [6:0] ctl;
    IDEX_MulDiv = 1; IDEX_MemRead = 1; IDEX_RegDst = 5;
    IFID_RegisterRs = 5; ID_UsesRs = 1;
    #1;
    checks++;
    if (IDEX_Bubble !== 1'b0 || IDEX_Write !== 1'b0 ||
        EXMEM_Bubble !== 1'b1) begin
      errors++;
      $display("FAIL md_prio got bub=%b wr=%b exb=%b want 0 0 1",
               IDEX_Bubble, IDEX_Write, EXMEM_Bubble);
    end
    tick();
    #1;
    checks++;
    if (Busy !== 1'b1 || Stall_Count !== 4'd13) begin
      errors++;
      $display("FAIL md_busy got busy=%b cnt=%0d want 1 13",
               Busy, Stall_Count);
    end
    Reset = 1;
    #1;
    ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
           IDEX_Bubble, EXMEM_Bubble, Busy};
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++;
      $display("FAIL rst_mid_ctl got %b want 1101000", ctl);
    end
    tick();
    Reset = 0;
    clr();
    #1;
    checks++;
    if (Busy !== 1'b0 || Stall_Count !== 4'd0 ||
        PC_Write !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got busy=%b cnt=%0d pc=%b want 0 0 1",
               Busy, Stall_Count, PC_Write);
    end
  endtask

  task automatic test_saturate();
    IDEX_MemRead = 1; IDEX_RegDst = 3;
    IFID_RegisterRt = 3; ID_UsesRt = 1;
    for (int i = 0; i < 20; i++) tick();
    #1;
    checks++;
    if (Stall_Count !== 4'hF || PC_Write !== 1'b0) begin
      errors++;
      $display("FAIL sat got cnt=%0d pc=%b want 15 0",
               Stall_Count, PC_Write);
    end
    clr();
    tick();
    #1;
    checks++;
    if (Stall_Count !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold got %0d want 15", Stall_Count);
    end
  endtask

  initial begin
    Reset = 1;
    clr();
    test_reset();
    test_load_use();
    test_dst_zero();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_md_priority_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
